// File: rtl/mgmt_bus_responder.sv
// Target end of the byte-wide management bus: ID, STATUS, latched cycle counter,
// scratch RAM and a mock crypto engine, with a fixed-latency pipelined read path.
module mgmt_bus_responder #(
  parameter logic [31:0] DEVICE_ID     = 32'h4C50_0001,
  parameter int unsigned READ_LATENCY  = 1,
  parameter int unsigned CRYPT_LATENCY = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic [15:0] rd_addr,
  output logic        rd_valid,
  output logic [7:0]  rd_data,
  input  logic        wr_en,
  input  logic [15:0] wr_addr,
  input  logic [7:0]  wr_data,
  output logic        crypt_out_valid,
  output logic        crypt_busy
);

  localparam int unsigned CW = $clog2(CRYPT_LATENCY + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic          w_busy, w_cov;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_cycles, r_snap;
  logic          r_done, r_unmapped;
  logic [7:0]    r_operand [32];
  logic [7:0]    r_op_snap [32];
  logic [7:0]    r_result  [32];
  logic [7:0]    r_scratch [256];
  logic          r_pv [1:READ_LATENCY];
  logic [7:0]    r_pd [1:READ_LATENCY];
  logic [7:0]    w_rdata;
  logic          w_wr_status, w_wr_op, w_wr_scr, w_wr_start, w_unm_evt, w_finish;

  function automatic logic is_mapped(input logic [15:0] a);
    return (a <= 16'h0004) || (a >= 16'h0008 && a <= 16'h000B) || (a == 16'h0010) ||
           (a >= 16'h0020 && a <= 16'h005F) || (a[15:8] == 8'h10);
  endfunction

  always_comb begin
    w_rdata = '0;
    if (rd_addr <= 16'h0003)                          w_rdata = DEVICE_ID[{rd_addr[1:0], 3'b000} +: 8];
    else if (rd_addr == 16'h0004)                     w_rdata = {5'b0, r_unmapped, r_done, w_busy};
    else if (rd_addr == 16'h0008)                     w_rdata = r_cycles[7:0];
    else if (rd_addr >= 16'h0009 && rd_addr <= 16'h000B) w_rdata = r_snap[{rd_addr[1:0], 3'b000} +: 8];
    else if (rd_addr[15:5] == 11'h001)                w_rdata = r_operand[rd_addr[4:0]];
    else if (rd_addr[15:5] == 11'h002)                w_rdata = r_result[rd_addr[4:0]];
    else if (rd_addr[15:8] == 8'h10)                  w_rdata = r_scratch[rd_addr[7:0]];
  end

  assign w_wr_status = wr_en && (wr_addr == 16'h0004);
  assign w_wr_op     = wr_en && (wr_addr[15:5] == 11'h001);
  assign w_wr_scr    = wr_en && (wr_addr[15:8] == 8'h10);
  assign w_wr_start  = wr_en && (wr_addr == 16'h0010) && wr_data[0] && (r_state == S_IDLE);
  assign w_unm_evt   = (rd_en && !is_mapped(rd_addr)) || (wr_en && !is_mapped(wr_addr));
  assign w_finish    = (r_state == S_RUN) && (w_state_nxt == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Down-counter is loaded with LATENCY-1 and DONE is entered as it would reach
  // zero, so the pulse lands exactly CRYPT_LATENCY cycles after the start write.
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_cov       = 1'b0;
    case (r_state)
      S_IDLE: if (w_wr_start) w_state_nxt = S_RUN;
      S_RUN: begin
        w_busy = 1'b1;
        if (r_cnt == CW'(1)) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_cov       = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign crypt_busy      = w_busy;
  assign crypt_out_valid = w_cov;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycles   <= '0;
      r_snap     <= '0;
      r_done     <= 1'b0;
      r_unmapped <= 1'b0;
      r_cnt      <= '0;
      for (int unsigned i = 0; i < 32; i++) begin
        r_operand[i] <= '0;
        r_op_snap[i] <= '0;
        r_result[i]  <= '0;
      end
    end else begin
      r_cycles <= r_cycles + 32'd1;
      if (rd_en && rd_addr == 16'h0008) r_snap <= r_cycles;
      if (w_wr_op) r_operand[wr_addr[4:0]] <= wr_data;
      if (w_wr_start) begin
        r_cnt <= CW'(CRYPT_LATENCY - 1);
        for (int unsigned i = 0; i < 32; i++) r_op_snap[i] <= r_operand[i];
      end else if (r_state == S_RUN) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_finish) begin
        for (int unsigned i = 0; i < 32; i++)
          r_result[i] <= r_op_snap[i] ^ r_op_snap[(i + 1) % 32] ^ 8'hA5;
      end
      if (w_finish)                       r_done <= 1'b1;
      else if (w_wr_status && wr_data[1]) r_done <= 1'b0;
      if (w_unm_evt)                      r_unmapped <= 1'b1;
      else if (w_wr_status && wr_data[2]) r_unmapped <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_scr && !rst) r_scratch[wr_addr[7:0]] <= wr_data;
  end

  // Data stages only advance with a valid token, so the last stage holds rd_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 1; i <= READ_LATENCY; i++) begin
        r_pv[i] <= 1'b0;
        r_pd[i] <= '0;
      end
    end else begin
      r_pv[1] <= rd_en;
      if (rd_en) r_pd[1] <= w_rdata;
      for (int unsigned i = 2; i <= READ_LATENCY; i++) begin
        r_pv[i] <= r_pv[i-1];
        if (r_pv[i-1]) r_pd[i] <= r_pd[i-1];
      end
    end
  end

  assign rd_valid = r_pv[READ_LATENCY];
  assign rd_data  = r_pd[READ_LATENCY];

endmodule

// File: tb/tb_mgmt_bus_responder.sv
// Bench for mgmt_bus_responder: directed scenarios plus random bus traffic,
// checked every cycle against a cycle-indexed behavioural model.
module tb_mgmt_bus_responder;

  localparam int unsigned RL     = 2;
  localparam int unsigned CL     = 16;
  localparam logic [31:0] DEV_ID = 32'h4C50_0001;

  logic        clk = 1'b0, rst = 1'b1;
  logic        rd_en = 1'b0, wr_en = 1'b0;
  logic [15:0] rd_addr = '0, wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic        rd_valid, crypt_out_valid, crypt_busy;
  logic [7:0]  rd_data;

  mgmt_bus_responder #(.DEVICE_ID(DEV_ID), .READ_LATENCY(RL), .CRYPT_LATENCY(CL)) dut (
    .clk(clk), .rst(rst),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .crypt_out_valid(crypt_out_valid), .crypt_busy(crypt_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_no);
    end
  endtask

  // Reference model state
  logic [31:0] mcnt;
  logic [31:0] m_snap;
  bit          m_done, m_unm, m_pend;
  logic [7:0]  m_op [32], m_opsnap [32], m_res [32], m_scr [256];
  bit          m_scr_ok [256];
  int          m_tstart = -1000, m_done_cyc = -1, cyc_no = 0;
  bit          mon_en = 1'b0;
  logic [7:0]  last_data;

  typedef struct { int cyc; logic [7:0] data; bit known; } rd_exp_t;
  rd_exp_t rq [$];

  logic [15:0] unm_tab [12] = '{16'h0005, 16'h0006, 16'h0007, 16'h000C, 16'h000F, 16'h0011,
                                16'h001F, 16'h0060, 16'h0FFF, 16'h1100, 16'h2000, 16'hFFFF};

  always @(posedge clk) mcnt <= rst ? 32'd0 : mcnt + 32'd1;

  function automatic bit mapped(input logic [15:0] a);
    return (a <= 4) || (a >= 8 && a <= 11) || (a == 16) || (a >= 32 && a < 96) ||
           (a >= 16'h1000 && a < 16'h1100);
  endfunction

  function automatic bit busy_now();
    return m_pend && (cyc_no > m_tstart);
  endfunction

  task automatic model_read(input logic [15:0] a, output logic [7:0] d, output bit known);
    known = 1'b1;
    d     = 8'h00;
    if (a < 4)                         d = 8'(DEV_ID >> (8 * a));
    else if (a == 4)                   d = {5'b0, m_unm, m_done, busy_now()};
    else if (a == 8)                   d = mcnt[7:0];
    else if (a >= 9 && a <= 11)        d = 8'(m_snap >> (8 * (a - 8)));
    else if (a >= 32 && a < 64)        d = m_op[a - 32];
    else if (a >= 64 && a < 96)        d = m_res[a - 64];
    else if (a >= 16'h1000 && a < 16'h1100) begin
      d     = m_scr[a - 16'h1000];
      known = m_scr_ok[a - 16'h1000];
    end
  endtask

  task automatic model_reset();
    m_snap = '0; m_done = 0; m_unm = 0; m_pend = 0; m_done_cyc = -1; m_tstart = -1000;
    for (int i = 0; i < 32; i++) begin m_op[i] = '0; m_res[i] = '0; end
    rq.delete();
    last_data = '0;
    mon_en = 1'b1;
  endtask

  // One bus cycle: advance the model to this cycle, then drive and account for inputs.
  task automatic step(input bit r, input logic [15:0] ra, input bit w, input logic [15:0] wa,
                      input logic [7:0] wd, input bit rs);
    logic [7:0] d;
    bit known, unm_set;
    @(posedge clk); #1;
    cyc_no++;
    if (rst) model_reset();
    if (m_pend && cyc_no == m_tstart + int'(CL)) begin
      for (int i = 0; i < 32; i++) m_res[i] = m_opsnap[i] ^ m_opsnap[(i + 1) % 32] ^ 8'hA5;
      m_done = 1; m_pend = 0; m_done_cyc = cyc_no;
    end
    rst = rs; rd_en = r; rd_addr = ra; wr_en = w; wr_addr = wa; wr_data = wd;
    unm_set = 0;
    if (!rs) begin
      if (r) begin
        model_read(ra, d, known);
        rq.push_back('{cyc_no + int'(RL), d, known});
        if (ra == 8) m_snap = mcnt;
        if (!mapped(ra)) unm_set = 1;
      end
      if (w) begin
        if (wa == 4) begin
          if (wd[1]) m_done = 0;
          if (wd[2]) m_unm = 0;
        end
        if (wa >= 32 && wa < 64) m_op[wa - 32] = wd;
        if (wa >= 16'h1000 && wa < 16'h1100) begin
          m_scr[wa - 16'h1000] = wd; m_scr_ok[wa - 16'h1000] = 1;
        end
        if (wa == 16 && wd[0] && !m_pend && cyc_no != m_done_cyc) begin
          m_opsnap = m_op; m_pend = 1; m_tstart = cyc_no;
        end
        if (!mapped(wa)) unm_set = 1;
      end
      if (unm_set) m_unm = 1;
    end
  endtask

  task automatic rd(input logic [15:0] a);                    step(1, a, 0, '0, '0, 0); endtask
  task automatic wr(input logic [15:0] a, input logic [7:0] v); step(0, '0, 1, a, v, 0); endtask
  task automatic idle(input int n); repeat (n) step(0, '0, 0, '0, '0, 0); endtask
  task automatic do_reset(input int n); repeat (n) step(1, 16'h0000, 0, '0, '0, 1); endtask

  always @(negedge clk) begin
    if (mon_en) begin
      bit exp_v;
      exp_v = (rq.size() > 0) && (rq[0].cyc == cyc_no);
      chk("rd_valid", 32'(rd_valid), 32'(exp_v));
      if (exp_v) begin
        if (rd_valid && rq[0].known) chk("rd_data", 32'(rd_data), 32'(rq[0].data));
        void'(rq.pop_front());
      end else if (!rd_valid) begin
        chk("rd_data_hold", 32'(rd_data), 32'(last_data));
      end
      last_data = rd_data;
      chk("crypt_busy", 32'(crypt_busy), 32'(busy_now()));
      chk("crypt_out_valid", 32'(crypt_out_valid), 32'(cyc_no == m_done_cyc));
    end
  end

  function automatic logic [15:0] pick_addr(input bit for_write);
    case ($urandom_range(0, 7))
      0:       return 16'($urandom_range(0, 4));
      1:       return 16'($urandom_range(8, 11));
      2:       return 16'(16'h0020 + $urandom_range(0, 31));
      3:       return 16'(16'h0040 + $urandom_range(0, 31));
      4, 5:    return 16'(16'h1000 + $urandom_range(0, 15));
      6:       return unm_tab[$urandom_range(0, 11)];
      default: return for_write ? 16'h0004 : 16'h0010;
    endcase
  endfunction

  initial begin
    do_reset(3);                        // rd_en held during reset must be dropped
    for (int a = 0; a <= 4; a++) rd(16'(a));
    idle(RL + 1);

    wr(16'h1000, 8'hDE); wr(16'h1001, 8'hAD); wr(16'h1002, 8'hBE); wr(16'h1003, 8'hEF);
    for (int a = 0; a < 4; a++) rd(16'(16'h1000 + a));
    wr(16'h1005, 8'h11);
    step(1, 16'h1005, 1, 16'h1005, 8'h22, 0);
    rd(16'h1005);
    idle(RL + 1);

    rd(16'h0008); idle(3); rd(16'h0009); idle(1); rd(16'h000A); idle(5); rd(16'h000B);
    idle(7); rd(16'h0008); rd(16'h000B); idle(RL + 1);

    for (int i = 0; i < 32; i++) wr(16'(16'h0020 + i), 8'(i));
    wr(16'h0010, 8'h01);
    idle(CL + 2);
    for (int i = 0; i < 32; i++) rd(16'(16'h0040 + i));
    rd(16'h0004); wr(16'h0004, 8'h02); rd(16'h0004);
    idle(RL + 1);

    wr(16'h0010, 8'h01); idle(3);
    wr(16'h0020, 8'hFF); wr(16'h0010, 8'h01);
    idle(CL);
    rd(16'h0040); rd(16'h005F); rd(16'h0020);
    wr(16'h0010, 8'h01); idle(CL - 1); wr(16'h0010, 8'h01);   // start in DONE cycle
    idle(4); rd(16'h0004);
    idle(RL + 1);

    wr(16'h0010, 8'h01); idle(5);
    do_reset(1); idle(2);
    rd(16'h0040); rd(16'h005F); rd(16'h0004);
    idle(CL + 2);

    wr(16'h0000, 8'h55); rd(16'h0004);
    rd(16'h2000); rd(16'h0004);
    for (int a = 0; a < 4; a++) rd(16'(a));
    wr(16'h0004, 8'h04); rd(16'h0004);
    idle(RL + 1);

    for (int n = 0; n < 3000; n++) begin
      bit r, w, rs;
      logic [15:0] ra, wa;
      logic [7:0]  wd;
      r  = bit'($urandom_range(0, 1));
      w  = bit'($urandom_range(0, 1));
      ra = pick_addr(0);
      wa = pick_addr(1);
      wd = 8'($urandom);
      rs = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 39) == 0) begin w = 1; wa = 16'h0010; end
      step(r, ra, w, wa, wd, rs);
    end
    idle(CL + RL + 2);
    chk("read_queue_drained", 32'(rq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
